// File: rtl/disp_line_serialiser.sv
// Display line serialiser: scans store lines, fetches one line per tube over req/ack,
// shifts each out LSB first with flyback blanking, and emits line/frame sync pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | scan stopped, all outputs low
// FETCH    | read request held for the current line until acknowledged
// SHIFT    | latched line shifted out, bit 0 first, BIT_PERIOD clocks/bit
// FLYBACK  | display blanked for BLANK_BITS bit-times, then next line
module disp_line_serialiser #(
    parameter int LINE_LENGTH    = 40,
    parameter int LINES_PER_TUBE = 64,
    parameter int ADDR_BITS      = 6,
    parameter int S_TUBES        = 2,
    parameter int BIT_PERIOD     = 2,
    parameter int BLANK_BITS     = 2
) (
    input  logic                           w_CLK,
    input  logic                           w_RST,
    input  logic                           w_DISP_EN,
    input  logic                           w_RD_ACK,
    input  logic [S_TUBES*LINE_LENGTH-1:0] b_RD_DATA,
    output logic                           w_RD_REQ,
    output logic [ADDR_BITS-1:0]           b_RD_ADDR,
    output logic [S_TUBES-1:0]             DISP_DATA,
    output logic                           w_LINE_SYNC,
    output logic                           w_FRAME_SYNC,
    output logic                           w_BUSY
);

    localparam int DW       = S_TUBES * LINE_LENGTH;
    localparam int MAX_BITS = (LINE_LENGTH > BLANK_BITS) ? LINE_LENGTH : BLANK_BITS;
    localparam int BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int PER_W    = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

    localparam logic [PER_W-1:0]     PER_LOAD   = PER_W'(BIT_PERIOD - 1);
    localparam logic [BIT_W-1:0]     LINE_LOAD  = BIT_W'(LINE_LENGTH - 1);
    localparam logic [BIT_W-1:0]     BLANK_LOAD = BIT_W'(BLANK_BITS - 1);
    localparam logic [ADDR_BITS-1:0] LAST_LINE  = ADDR_BITS'(LINES_PER_TUBE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_SHIFT   = 2'd2,
        S_FLYBACK = 2'd3
    } state_t;

    state_t               state_q, state_nxt;
    logic [ADDR_BITS-1:0] line_q, line_nxt;
    logic [PER_W-1:0]     per_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DW-1:0]        shreg_q;

    logic                 req_nxt, ls_nxt, fs_nxt, busy_nxt;
    logic [ADDR_BITS-1:0] addr_nxt;
    logic                 ack_hit, per_tc, bit_tc, phase_end;

    assign ack_hit   = w_RD_REQ & w_RD_ACK;
    assign per_tc    = (per_q == '0);
    assign bit_tc    = (bit_q == '0);
    assign phase_end = per_tc & bit_tc;

    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            state_q <= S_IDLE;
            line_q  <= '0;
        end else begin
            state_q <= state_nxt;
            line_q  <= line_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        line_nxt  = line_q;
        case (state_q)
            S_IDLE: begin
                if (w_DISP_EN) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (ack_hit) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (phase_end) state_nxt = S_FLYBACK;
            end
            S_FLYBACK: begin
                if (phase_end) begin
                    if (w_DISP_EN) begin
                        state_nxt = S_FETCH;
                        line_nxt  = (line_q == LAST_LINE) ? '0 : line_q + ADDR_BITS'(1);
                    end else begin
                        state_nxt = S_IDLE;
                        line_nxt  = '0;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that every port comes straight off a flop.
    always_comb begin
        req_nxt  = (state_nxt == S_FETCH);
        addr_nxt = (state_nxt == S_IDLE) ? '0 : line_nxt;
        ls_nxt   = (state_q == S_FETCH) && (state_nxt == S_SHIFT);
        fs_nxt   = ls_nxt && (line_q == '0);
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            w_RD_REQ     <= 1'b0;
            b_RD_ADDR    <= '0;
            w_LINE_SYNC  <= 1'b0;
            w_FRAME_SYNC <= 1'b0;
            w_BUSY       <= 1'b0;
        end else begin
            w_RD_REQ     <= req_nxt;
            b_RD_ADDR    <= addr_nxt;
            w_LINE_SYNC  <= ls_nxt;
            w_FRAME_SYNC <= fs_nxt;
            w_BUSY       <= busy_nxt;
        end
    end

    // After LINE_LENGTH shifts the register holds zeros, which is exactly the flyback level.
    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            per_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ack_hit) begin
                        per_q   <= PER_LOAD;
                        bit_q   <= LINE_LOAD;
                        shreg_q <= b_RD_DATA;
                    end
                end
                S_SHIFT, S_FLYBACK: begin
                    if (per_tc) begin
                        per_q <= PER_LOAD;
                        bit_q <= bit_tc ? BLANK_LOAD : bit_q - BIT_W'(1);
                        if (state_q == S_SHIFT) begin
                            for (int t = 0; t < S_TUBES; t++) begin
                                shreg_q[t*LINE_LENGTH +: LINE_LENGTH] <=
                                    shreg_q[t*LINE_LENGTH +: LINE_LENGTH] >> 1;
                            end
                        end
                    end else begin
                        per_q <= per_q - PER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar t = 0; t < S_TUBES; t++) begin : g_disp
        assign DISP_DATA[t] = shreg_q[t*LINE_LENGTH];
    end

endmodule

// File: tb/tb_disp_line_serialiser.sv
// Bench for disp_line_serialiser: expected per-cycle waveform of each line is built
// from the line timing rules (fetch wait, bits, flyback) and a simple address model.
module tb_disp_line_serialiser;

    localparam int L     = 40;
    localparam int LINES = 64;
    localparam int AB    = 6;
    localparam int ST    = 2;
    localparam int BP    = 2;
    localparam int BB    = 2;
    localparam int DW    = ST * L;
    localparam int OW    = 1 + AB + ST + 3;

    logic          clk = 1'b0;
    logic          rst, en, ack;
    logic [DW-1:0] rd_data;
    logic          rd_req, line_sync, frame_sync, busy;
    logic [AB-1:0] rd_addr;
    logic [ST-1:0] disp;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ls     = 0;
    int n_fs     = 0;

    typedef struct {
        int            ack_wait;
        logic [DW-1:0] data;
        int            drop_bit;
        int            spur_bit;
        int            e_addr;
        bit            e_frame;
    } vec_t;

    vec_t vecs[6];

    disp_line_serialiser #(
        .LINE_LENGTH(L), .LINES_PER_TUBE(LINES), .ADDR_BITS(AB),
        .S_TUBES(ST), .BIT_PERIOD(BP), .BLANK_BITS(BB)
    ) dut (
        .w_CLK       (clk),
        .w_RST       (rst),
        .w_DISP_EN   (en),
        .w_RD_ACK    (ack),
        .b_RD_DATA   (rd_data),
        .w_RD_REQ    (rd_req),
        .b_RD_ADDR   (rd_addr),
        .DISP_DATA   (disp),
        .w_LINE_SYNC (line_sync),
        .w_FRAME_SYNC(frame_sync),
        .w_BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (line_sync) n_ls++;
        if (frame_sync) n_fs++;
    endtask

    task automatic chk_outs(input string name, input logic e_req, input logic [AB-1:0] e_addr,
                            input logic [ST-1:0] e_disp, input logic e_ls, input logic e_fs,
                            input logic e_busy);
        logic [OW-1:0] act, want;
        act  = {rd_req, rd_addr, disp, line_sync, frame_sync, busy};
        want = {e_req, e_addr, e_disp, e_ls, e_fs, e_busy};
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got req=%b addr=%0d disp=%b lsync=%b fsync=%b busy=%b, expected req=%b addr=%0d disp=%b lsync=%b fsync=%b busy=%b",
                     name, $time, rd_req, rd_addr, disp, line_sync, frame_sync, busy,
                     e_req, e_addr, e_disp, e_ls, e_fs, e_busy);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Tube0: only bits 0 and L-1 set; tube1: alternating 1,0 starting at bit 0.
    function automatic logic [DW-1:0] pattern_line();
        logic [DW-1:0] d;
        d = '0;
        for (int b = 0; b < L; b++) begin
            d[b]     = (b == 0) || (b == L - 1);
            d[L + b] = (b % 2 == 0);
        end
        return d;
    endfunction

    function automatic vec_t mk_vec(input int w, input logic [DW-1:0] d, input int drop,
                                    input int spur, input int a, input bit f);
        vec_t v;
        v.ack_wait = w;
        v.data     = d;
        v.drop_bit = drop;
        v.spur_bit = spur;
        v.e_addr   = a;
        v.e_frame  = f;
        return v;
    endfunction

    // Entered on the first FETCH cycle; leaves on the cycle after flyback ends.
    task automatic do_line(input string tag, input int ack_wait, input logic [DW-1:0] data,
                           input int e_addr, input bit e_frame, input int drop_bit,
                           input int spur_bit, input int rst_bit);
        logic [ST-1:0] e_disp;
        bit            first;
        for (int i = 0; i <= ack_wait; i++) begin
            chk_outs({tag, " fetch"}, 1'b1, AB'(e_addr), '0, 1'b0, 1'b0, 1'b1);
            ack     = (i == ack_wait);
            rd_data = (i == ack_wait) ? data : rand_line();
            tick();
        end
        ack = 1'b0;
        for (int b = 0; b < L; b++) begin
            for (int p = 0; p < BP; p++) begin
                for (int t = 0; t < ST; t++) e_disp[t] = data[t*L + b];
                first = (b == 0) && (p == 0);
                chk_outs({tag, " shift"}, 1'b0, AB'(e_addr), e_disp, first, first && e_frame, 1'b1);
                rd_data = rand_line();
                ack     = (b == spur_bit) && (p == BP - 1);
                if (b == drop_bit && p == 0) en = 1'b0;
                if (b == rst_bit && p == 0) begin
                    rst = 1'b1;
                    ack = 1'b0;
                    tick();
                    chk_outs({tag, " reset"}, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
                    rst = 1'b0;
                    return;
                end
                tick();
            end
        end
        ack = 1'b0;
        for (int k = 0; k < BB * BP; k++) begin
            chk_outs({tag, " flyback"}, 1'b0, AB'(e_addr), '0, 1'b0, 1'b0, 1'b1);
            rd_data = rand_line();
            tick();
        end
    endtask

    // Checks the idle state (including an ignored ack) and re-enables into FETCH.
    task automatic idle_reenable(input string tag);
        chk_outs({tag, " idle"}, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        ack     = 1'b1;
        rd_data = rand_line();
        tick();
        ack = 1'b0;
        chk_outs({tag, " idle spurious ack"}, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_outs({tag, " idle hold"}, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        tick();
    endtask

    initial begin
        int  m_addr;
        int  w, drop, spur;

        rst     = 1'b1;
        en      = 1'b0;
        ack     = 1'b0;
        rd_data = '0;
        tick();
        tick();
        chk_outs("reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        en      = 1'b1;
        ack     = 1'b1;
        rd_data = rand_line();
        tick();
        chk_outs("reset overrides inputs", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        en  = 1'b0;
        ack = 1'b0;
        rst = 1'b0;
        tick();
        idle_reenable("startup");

        vecs[0] = mk_vec(0, pattern_line(), -1, 5, 0, 1'b1);
        vecs[1] = mk_vec(5, rand_line(), -1, -1, 1, 1'b0);
        vecs[2] = mk_vec(2, rand_line(), -1, -1, 2, 1'b0);
        vecs[3] = mk_vec(0, rand_line(), 10, -1, 3, 1'b0);
        vecs[4] = mk_vec(0, pattern_line(), -1, 30, 0, 1'b1);
        vecs[5] = mk_vec(1, rand_line(), -1, -1, 1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_line($sformatf("vec%0d", i), vecs[i].ack_wait, vecs[i].data, vecs[i].e_addr,
                    vecs[i].e_frame, vecs[i].drop_bit, vecs[i].spur_bit, -1);
            if (vecs[i].drop_bit >= 0) idle_reenable($sformatf("vec%0d drop", i));
        end

        for (int a = 2; a < 7; a++) do_line("pre-reset", 0, rand_line(), a, 1'b0, -1, -1, -1);
        do_line("line7", 0, rand_line(), 7, 1'b0, -1, -1, 20);
        tick();

        n_ls = 0;
        n_fs = 0;
        for (int i = 0; i < LINES + 1; i++)
            do_line("wrap", 0, rand_line(), i % LINES, (i % LINES) == 0, -1, -1, -1);
        chk_int("line_sync count", n_ls, LINES + 1);
        chk_int("frame_sync count", n_fs, 2);

        m_addr = (LINES + 1) % LINES;
        for (int i = 0; i < 30; i++) begin
            w    = $urandom_range(0, 6);
            drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, L - 1)) : -1;
            spur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L - 1)) : -1;
            do_line("random", w, rand_line(), m_addr, m_addr == 0, drop, spur, -1);
            if (drop >= 0) begin
                idle_reenable("random drop");
                m_addr = 0;
            end else begin
                m_addr = (m_addr + 1) % LINES;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
